// File: rtl/multi_edge_detector.sv
// N-channel synchronised, debounced edge detector with per-channel edge-mode select.
// Optional per-channel saturating event counters when EDGE_EVENT_COUNT_EN is defined.
//
// state     | meaning
// STABLE_LO | debounced level 0, input agrees
// PEND_HI   | input high, counting consecutive high ticks
// STABLE_HI | debounced level 1, input agrees
// PEND_LO   | input low, counting consecutive low ticks
module multi_edge_detector #(
    parameter int N_CH     = 4,
    parameter int TICK_DIV = 16,
    parameter int DB_TICKS = 4,
    parameter int CNT_W    = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic [N_CH-1:0]       i_lvl,
    input  logic [2*N_CH-1:0]     i_mode,
    input  logic                  i_cnt_clr,
    output logic                  o_tick,
    output logic [N_CH-1:0]       o_lvl,
    output logic [N_CH-1:0]       o_edge,
    output logic [N_CH*CNT_W-1:0] o_evt_cnt
);
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DB_W   = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;

    typedef enum logic [1:0] {STABLE_LO, PEND_HI, STABLE_HI, PEND_LO} state_t;

    logic [TICK_W-1:0] r_tick_cnt;
    logic              w_tick;
    logic [N_CH-1:0]   r_sync1;
    logic [N_CH-1:0]   r_sync2;
    state_t            r_state  [N_CH];
    logic [DB_W-1:0]   r_db_cnt [N_CH];
    logic [N_CH-1:0]   w_diff;
    logic [N_CH-1:0]   w_accept;
    logic [N_CH-1:0]   w_rise_en;
    logic [N_CH-1:0]   w_fall_en;

    assign w_tick = i_en && (r_tick_cnt == TICK_W'(TICK_DIV - 1));
    assign o_tick = w_tick;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else if (i_en) begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_lvl;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_mode
        assign w_rise_en[g] = i_mode[2*g];
        assign w_fall_en[g] = i_mode[2*g+1];
    end

    // Accept fires on the DB_TICKS-th consecutive differing tick; with DB_TICKS=1 straight from STABLE.
    always_comb begin
        w_diff   = '0;
        w_accept = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_diff[i] = r_sync2[i] ^ o_lvl[i];
            if (DB_TICKS == 1) begin
                w_accept[i] = w_diff[i];
            end else begin
                w_accept[i] = w_diff[i]
                            && ((r_state[i] == PEND_HI) || (r_state[i] == PEND_LO))
                            && (r_db_cnt[i] == DB_W'(DB_TICKS - 1));
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                r_state[i]  <= STABLE_LO;
                r_db_cnt[i] <= '0;
            end
            o_lvl  <= '0;
            o_edge <= '0;
        end else begin
            o_edge <= '0;
            if (w_tick) begin
                for (int i = 0; i < N_CH; i++) begin
                    if (w_accept[i]) begin
                        o_lvl[i]    <= r_sync2[i];
                        o_edge[i]   <= r_sync2[i] ? w_rise_en[i] : w_fall_en[i];
                        r_db_cnt[i] <= '0;
                        r_state[i]  <= r_sync2[i] ? STABLE_HI : STABLE_LO;
                    end else begin
                        case (r_state[i])
                            STABLE_LO: begin
                                if (w_diff[i]) begin
                                    r_db_cnt[i] <= DB_W'(1);
                                    r_state[i]  <= PEND_HI;
                                end
                            end
                            STABLE_HI: begin
                                if (w_diff[i]) begin
                                    r_db_cnt[i] <= DB_W'(1);
                                    r_state[i]  <= PEND_LO;
                                end
                            end
                            PEND_HI: begin
                                if (!w_diff[i]) begin
                                    r_db_cnt[i] <= '0;
                                    r_state[i]  <= STABLE_LO;
                                end else begin
                                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                                end
                            end
                            PEND_LO: begin
                                if (!w_diff[i]) begin
                                    r_db_cnt[i] <= '0;
                                    r_state[i]  <= STABLE_HI;
                                end else begin
                                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                                end
                            end
                            default: begin
                                r_db_cnt[i] <= '0;
                                r_state[i]  <= STABLE_LO;
                            end
                        endcase
                    end
                end
            end
        end
    end

`ifdef EDGE_EVENT_COUNT_EN
    logic [CNT_W-1:0] r_evt_cnt [N_CH];

    // Clear takes priority over a coincident increment; counters stick at all-ones.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                r_evt_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (i_cnt_clr) begin
                    r_evt_cnt[i] <= '0;
                end else if (o_edge[i] && (r_evt_cnt[i] != {CNT_W{1'b1}})) begin
                    r_evt_cnt[i] <= r_evt_cnt[i] + 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_cnt
        assign o_evt_cnt[CNT_W*g +: CNT_W] = r_evt_cnt[g];
    end
`else
    logic w_unused_cnt_clr;
    assign w_unused_cnt_clr = i_cnt_clr;
    assign o_evt_cnt        = '0;
`endif

endmodule
